proj_extender_ctrl: RTL and testbench
=====================================

PROJ_EXTENDER_CTRL -- requirements
Module: proj_extender_ctrl

Interface
- REQ-001 Parameters SHALL be: INDICES_COUNT = SORTER_EXTENDER_INDICES_COUNT (k-mer indices per batch); INDICE_LEN = INDICE_LEN (unsigned index width); SIGNED_INDICE_LEN = SIGNED_INDICE_LEN (signed address width); FRAG_LEN_BITS = FM_EXTENDER_FRAG_LEN_BITS (fragment width); FRAG_PART = EXTENDER_OUT_PART_LEN (bits per part); FRAG_PART_ONE_HOT = EXTENDER_OUT_PART_LEN_ONE_HOT (one-hot part width); FRAG_OFFSET = EXTENDER_FRAG_OFFSET (window start relative to index); PARTS_COUNT = FRAG_LEN_BITS/FRAG_PART.
- REQ-002 The block SHALL use one clock, clk, and an asynchronous, active-low reset, rst_n.
- REQ-003 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  in_valid  in  1  index batch valid
  in_ready  out  1  batch accepted when both high
  in_kmer_indices  in  INDICES_COUNT x INDICE_LEN  index batch
  flush  in  1  synchronous abort
  mem_req  out  1  fragment read request
  mem_addr  out  SIGNED_INDICE_LEN  signed window start
  mem_gnt  in  1  request accepted
  mem_rvalid  in  1  read data valid
  mem_rdata  in  FRAG_LEN_BITS  zero-padded fragment
  ext_fragment  out  FRAG_LEN_BITS  fragment held for extender
  ext_part_sel  out  clog2(PARTS_COUNT)  part select to extender
  ext_gfm  in  FRAG_PART_ONE_HOT  extender one-hot part
  out_valid  out  1  gfm part valid
  out_ready  in  1  downstream ready
  out_gfm  out  FRAG_PART_ONE_HOT  forwarded ext_gfm
  out_kmer_num  out  clog2(INDICES_COUNT)  index number in batch
  out_last  out  1  last part of last index
  busy  out  1  state != IDLE

Function
- REQ-004 FSM states SHALL be IDLE, FETCH, WAIT, EMIT.
- REQ-005 IDLE: in_ready=1; on in_valid, latch batch, clear index counter k and part counter p, go FETCH next cycle.
- REQ-006 FETCH: mem_req=1, mem_addr = zero-extended in_kmer_indices[k] minus FRAG_OFFSET in SIGNED_INDICE_LEN two's complement (negative allowed); on mem_gnt go WAIT.
- REQ-007 WAIT: on mem_rvalid, register mem_rdata into ext_fragment, go EMIT; mem_rvalid outside WAIT SHALL be ignored.
- REQ-008 EMIT: out_valid=1, ext_part_sel=p, out_gfm=ext_gfm, out_kmer_num=k; p advances only on out_valid&&out_ready; out_gfm/out_kmer_num SHALL stay stable while stalled.
- REQ-009 On handshake with p=PARTS_COUNT-1: if k<INDICES_COUNT-1, k++, p=0, go FETCH; else go IDLE.
- REQ-010 out_last SHALL be 1 only in EMIT with p=PARTS_COUNT-1 and k=INDICES_COUNT-1.
- REQ-011 flush SHALL force IDLE next cycle from any state, drop mem_req and out_valid, discard the batch; flush has priority over all other events.
- REQ-012 Minimum latency, batch accept to first out_valid: 3 cycles with mem_gnt in the first FETCH cycle and mem_rvalid in the first WAIT cycle.
- REQ-013 in_ready SHALL be 0 in every state but IDLE; mem_addr SHALL be stable while mem_req=1 and mem_gnt=0.

Reset
- REQ-014 While rst_n=0: state=IDLE, k=0, p=0, ext_fragment=0, mem_req=0, mem_addr=0, out_valid=0, out_last=0, busy=0, in_ready=0; in_ready=1 from the first clock after release.
- REQ-015 Reset mid-operation SHALL abandon the batch without emitting further parts.

Structure
- REQ-016 FSM state enum, EXTENDER_FRAG_OFFSET and PARTS_COUNT SHALL be defined in proj_pkg.
- REQ-017 The block SHALL be one module; the extender is instantiated beside it at the top level, not inside it.

Verification (INDICES_COUNT=4, PARTS_COUNT=4, FRAG_OFFSET=8)
- REQ-018 Batch {5,0,31,12}, memory zero-wait -> mem_addr -3,-8,23,4 in order; 16 out_gfm parts; out_last on the 16th only.
- REQ-019 out_ready held low 5 cycles in EMIT p=1 -> out_gfm and out_kmer_num frozen, p unchanged, then resume at p=2.
- REQ-020 mem_gnt delayed 3 cycles, mem_rvalid delayed 4 -> mem_addr stable throughout; output sequence identical to REQ-018.
- REQ-021 flush during WAIT, then late mem_rvalid -> state IDLE, ext_fragment unchanged, no out_valid; next batch runs normally.
- REQ-022 rst_n low during EMIT k=2 -> all outputs at reset values immediately; in_ready=1 after release.
- REQ-023 in_valid held high during EMIT -> no second batch latched until IDLE.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared constants and FSM encoding for the k-mer fragment extender controller.
// The extender datapath and its controller both import this package.
package proj_pkg;

  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int EXT_INDICE_LEN = 8;
  localparam int EXT_SIGNED_INDICE_LEN = 9;
  localparam int FM_EXTENDER_FRAG_LEN_BITS = 32;
  localparam int EXTENDER_OUT_PART_LEN = 8;
  localparam int EXTENDER_OUT_PART_LEN_ONE_HOT = 16;
  localparam int EXTENDER_FRAG_OFFSET = 8;
  localparam int PARTS_COUNT =
    FM_EXTENDER_FRAG_LEN_BITS / EXTENDER_OUT_PART_LEN;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_EMIT  = 2'd3;

endpackage

// File: rtl/proj_extender_ctrl_if.sv
// Batch input, fragment memory and extender/output signals of the controller.
// master = controller side, slave = environment side.
interface proj_extender_ctrl_if #(
  parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN = proj_pkg::EXT_INDICE_LEN,
  parameter int SIGNED_INDICE_LEN = proj_pkg::EXT_SIGNED_INDICE_LEN,
  parameter int FRAG_LEN_BITS = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
  parameter int FRAG_PART = proj_pkg::EXTENDER_OUT_PART_LEN,
  parameter int FRAG_PART_ONE_HOT = proj_pkg::EXTENDER_OUT_PART_LEN_ONE_HOT,
  parameter int PARTS_COUNT = FRAG_LEN_BITS / FRAG_PART
);

  localparam int SEL_W = $clog2(PARTS_COUNT);
  localparam int NUM_W = $clog2(INDICES_COUNT);

  logic in_valid;
  logic in_ready;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_kmer_indices;

  logic mem_req;
  logic [SIGNED_INDICE_LEN-1:0] mem_addr;
  logic mem_gnt;
  logic mem_rvalid;
  logic [FRAG_LEN_BITS-1:0] mem_rdata;

  logic [FRAG_LEN_BITS-1:0] ext_fragment;
  logic [SEL_W-1:0] ext_part_sel;
  logic [FRAG_PART_ONE_HOT-1:0] ext_gfm;

  logic out_valid;
  logic out_ready;
  logic [FRAG_PART_ONE_HOT-1:0] out_gfm;
  logic [NUM_W-1:0] out_kmer_num;
  logic out_last;

  modport master (
    input  in_valid, in_kmer_indices,
    output in_ready,
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ext_fragment, ext_part_sel,
    input  ext_gfm,
    output out_valid, out_gfm, out_kmer_num, out_last,
    input  out_ready
  );

  modport slave (
    output in_valid, in_kmer_indices,
    input  in_ready,
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ext_fragment, ext_part_sel,
    output ext_gfm,
    input  out_valid, out_gfm, out_kmer_num, out_last,
    output out_ready
  );

endinterface

// File: rtl/proj_extender_ctrl.sv
// Walks a batch of k-mer indices: fetches each fragment window, then streams
// its parts through the neighbouring extender to the downstream consumer.
module proj_extender_ctrl #(
  parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN = proj_pkg::EXT_INDICE_LEN,
  parameter int SIGNED_INDICE_LEN = proj_pkg::EXT_SIGNED_INDICE_LEN,
  parameter int FRAG_LEN_BITS = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
  parameter int FRAG_PART = proj_pkg::EXTENDER_OUT_PART_LEN,
  parameter int FRAG_PART_ONE_HOT = proj_pkg::EXTENDER_OUT_PART_LEN_ONE_HOT,
  parameter int FRAG_OFFSET = proj_pkg::EXTENDER_FRAG_OFFSET,
  parameter int PARTS_COUNT = FRAG_LEN_BITS / FRAG_PART
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  output logic busy,
  proj_extender_ctrl_if.master bus
);

  import proj_pkg::*;

  localparam int SEL_W = $clog2(PARTS_COUNT);
  localparam int NUM_W = $clog2(INDICES_COUNT);
  localparam logic [SEL_W-1:0] P_LAST = SEL_W'(PARTS_COUNT - 1);
  localparam logic [NUM_W-1:0] K_LAST = NUM_W'(INDICES_COUNT - 1);

  state_t state_q;
  state_t state_d;
  logic init_q;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] idx_q;
  logic [NUM_W-1:0] k_q;
  logic [SEL_W-1:0] p_q;
  logic [FRAG_LEN_BITS-1:0] frag_q;
  logic [SIGNED_INDICE_LEN-1:0] win_addr;

  logic st_idle;
  logic st_fetch;
  logic st_wait;
  logic st_emit;
  logic accept;
  logic out_hs;
  logic p_end;
  logic k_end;

  assign st_idle  = (state_q == ST_IDLE);
  assign st_fetch = (state_q == ST_FETCH);
  assign st_wait  = (state_q == ST_WAIT);
  assign st_emit  = (state_q == ST_EMIT);

  assign p_end = (p_q == P_LAST);
  assign k_end = (k_q == K_LAST);

  assign accept = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_valid && bus.out_ready;

  // Window may start before index 0, so the address is signed.
  assign win_addr = SIGNED_INDICE_LEN'(idx_q[k_q])
                  - SIGNED_INDICE_LEN'(FRAG_OFFSET);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (accept) state_d = ST_FETCH;
        end
        st_fetch: begin
          if (bus.mem_gnt) state_d = ST_WAIT;
        end
        st_wait: begin
          if (bus.mem_rvalid) state_d = ST_EMIT;
        end
        st_emit: begin
          if (out_hs && p_end) begin
            state_d = k_end ? ST_IDLE : ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
      idx_q   <= '0;
      k_q     <= '0;
      p_q     <= '0;
      frag_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (!flush) begin
        if (accept) begin
          idx_q <= bus.in_kmer_indices;
          k_q   <= '0;
          p_q   <= '0;
        end
        if (st_wait && bus.mem_rvalid) begin
          frag_q <= bus.mem_rdata;
        end
        if (out_hs) begin
          if (p_end) begin
            p_q <= '0;
            if (!k_end) k_q <= k_q + 1'b1;
          end else begin
            p_q <= p_q + 1'b1;
          end
        end
      end
    end
  end

  // init_q keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = st_idle && init_q && !flush;

  assign bus.mem_req  = st_fetch && !flush;
  assign bus.mem_addr = st_fetch ? win_addr : '0;

  assign bus.ext_fragment = frag_q;
  assign bus.ext_part_sel = p_q;

  assign bus.out_valid    = st_emit && !flush;
  assign bus.out_gfm      = bus.ext_gfm;
  assign bus.out_kmer_num = k_q;
  assign bus.out_last     = st_emit && !flush && p_end && k_end;

  assign busy = !st_idle;

endmodule

// File: tb/tb_proj_extender_ctrl.sv
// Scoreboard bench for proj_extender_ctrl with a stand-in memory and extender.
// Stimulus pushes expectations; a negedge monitor pops and compares them.
module tb_proj_extender_ctrl;

  import proj_pkg::*;

  localparam int IC = SORTER_EXTENDER_INDICES_COUNT;
  localparam int IL = EXT_INDICE_LEN;
  localparam int SL = EXT_SIGNED_INDICE_LEN;
  localparam int FL = FM_EXTENDER_FRAG_LEN_BITS;
  localparam int FP = EXTENDER_OUT_PART_LEN;
  localparam int OH = EXTENDER_OUT_PART_LEN_ONE_HOT;
  localparam int PC = PARTS_COUNT;

  typedef struct {
    logic [OH-1:0] gfm;
    int k;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  proj_extender_ctrl_if bus ();

  proj_extender_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Stand-in extender: selected fragment byte plus a part tag.
  assign bus.ext_gfm = {bus.ext_fragment[int'(bus.ext_part_sel)*FP +: FP],
                        8'hC0 | 8'(bus.ext_part_sel)};

  int total = 0;
  int bad = 0;
  int accepts = 0;
  int n_out = 0;
  int gnt_delay = 0;
  int rv_delay = 0;
  bit saw_rv = 0;

  exp_t exp_q[$];
  logic [SL-1:0] addr_q[$];

  function automatic logic [FL-1:0] mem_frag(input logic [SL-1:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b ^ 8'h5A, b + 8'd1, ~b, b};
  endfunction

  function automatic logic [OH-1:0] gfm_of(input logic [FL-1:0] f,
                                           input int p);
    return {f[p*FP +: FP], 8'hC0 | 8'(p)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_batch(input int addrs[IC], input bit outs);
    exp_t e;
    for (int k = 0; k < IC; k++) begin
      addr_q.push_back(SL'(addrs[k]));
      if (outs) begin
        for (int p = 0; p < PC; p++) begin
          e.gfm = gfm_of(mem_frag(SL'(addrs[k])), p);
          e.k = k;
          e.last = (k == IC - 1) && (p == PC - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic set_idx(input int ids[IC]);
    for (int i = 0; i < IC; i++) bus.in_kmer_indices[i] = IL'(ids[i]);
  endtask

  task automatic issue(input int ids[IC]);
    @(posedge clk); #1;
    set_idx(ids);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < budget);
    chk(name, n < budget, 1);
  endtask

  // Memory responder: grant after gnt_delay, data rv_delay cycles later.
  initial begin
    int gcnt;
    int rcnt;
    bit pend;
    logic [SL-1:0] paddr;
    gcnt = 0;
    rcnt = 0;
    pend = 0;
    paddr = '0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 0;
        gcnt = 0;
      end else if (pend) begin
        if (rcnt >= rv_delay) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = mem_frag(paddr);
          pend = 0;
        end else begin
          rcnt++;
        end
      end else if (bus.mem_req) begin
        if (gcnt >= gnt_delay) begin
          bus.mem_gnt = 1'b1;
          paddr = bus.mem_addr;
          pend = 1;
          rcnt = 0;
          gcnt = 0;
        end else begin
          gcnt++;
        end
      end else begin
        gcnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit prev_req;
    bit prev_gnt;
    logic [SL-1:0] prev_addr;
    logic [SL-1:0] a;
    exp_t e;
    prev_req = 0;
    prev_gnt = 0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 0;
      end else begin
        if (bus.mem_rvalid) saw_rv = 1;
        if (bus.mem_req) begin
          if (prev_req && !prev_gnt)
            chk("mem_addr_stable", bus.mem_addr, prev_addr);
          if (bus.mem_gnt) begin
            if (addr_q.size() == 0) begin
              chk("mem_addr_unexpected", bus.mem_addr, '1);
            end else begin
              a = addr_q.pop_front();
              chk("mem_addr", bus.mem_addr, a);
            end
          end
        end
        prev_req = bus.mem_req;
        prev_gnt = bus.mem_gnt;
        prev_addr = bus.mem_addr;
        if (bus.in_valid && bus.in_ready) accepts++;
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            chk("out_unexpected", bus.out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_gfm", bus.out_gfm, e.gfm);
            chk("out_kmer_num", bus.out_kmer_num, e.k);
            chk("out_last", bus.out_last, e.last);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int n0;
    int a0;
    logic [OH-1:0] g0;
    logic [FL-1:0] f0;

    bus.in_valid = 1'b0;
    bus.in_kmer_indices = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_fragment", bus.ext_fragment, 0);
    chk("rst_part_sel", bus.ext_part_sel, 0);
    chk("rst_kmer_num", bus.out_kmer_num, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Zero-wait batch and minimum latency.
    n0 = n_out;
    push_batch('{-3, -8, 23, 4}, 1);
    set_idx('{5, 0, 31, 12});
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("accept_b1", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 3);
    wait_done("done_b1", 200);
    chk("parts_b1", n_out - n0, 16);

    // Stall at k=0 p=1 for five cycles.
    n0 = n_out;
    push_batch('{2, 1, 0, 32}, 1);
    issue('{10, 9, 8, 40});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && bus.out_ready && bus.out_kmer_num == 0
                 && bus.ext_part_sel == 0) && n < 100);
    chk("stall_reach", n < 100, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    g0 = bus.out_gfm;
    chk("stall_sel", bus.ext_part_sel, 1);
    chk("stall_gfm_first", g0, gfm_of(mem_frag(SL'(2)), 1));
    repeat (4) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_gfm", bus.out_gfm, g0);
      chk("stall_kmer", bus.out_kmer_num, 0);
      chk("stall_p", bus.ext_part_sel, 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("done_stall", 200);
    chk("parts_stall", n_out - n0, 16);

    // Slow memory.
    gnt_delay = 3;
    rv_delay = 4;
    n0 = n_out;
    push_batch('{-3, -8, 23, 4}, 1);
    issue('{5, 0, 31, 12});
    wait_done("done_slow", 400);
    chk("parts_slow", n_out - n0, 16);
    gnt_delay = 0;

    // Flush in WAIT, data arrives afterwards.
    rv_delay = 3;
    f0 = bus.ext_fragment;
    addr_q.push_back(SL'(-3));
    issue('{5, 0, 31, 12});
    n = 0;
    while (!bus.mem_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("flush_gnt_seen", n < 20, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    saw_rv = 0;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("flush_busy", busy, 0);
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_fragment", bus.ext_fragment, f0);
    end
    chk("flush_late_rvalid", saw_rv, 1);
    rv_delay = 0;
    n0 = n_out;
    push_batch('{12, 0, 92, 247}, 1);
    issue('{20, 8, 100, 255});
    wait_done("done_after_flush", 200);
    chk("parts_after_flush", n_out - n0, 16);

    // in_valid held high for the whole batch.
    a0 = accepts;
    n0 = n_out;
    push_batch('{-7, -6, -5, -4}, 1);
    @(posedge clk); #1;
    set_idx('{1, 2, 3, 4});
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_idx('{9, 9, 9, 9});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && bus.out_ready && bus.out_last) && n < 300);
    bus.in_valid = 1'b0;
    chk("hold_reach_last", n < 300, 1);
    wait_done("done_hold", 50);
    chk("hold_accepts", accepts - a0, 1);
    chk("parts_hold", n_out - n0, 16);

    // Reset during EMIT k=2.
    push_batch('{-3, -8, 23, 4}, 1);
    issue('{5, 0, 31, 12});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && bus.out_kmer_num == 2) && n < 200);
    chk("rst_reach_k2", n < 200, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last", bus.out_last, 0);
    chk("mid_rst_fragment", bus.ext_fragment, 0);
    chk("mid_rst_kmer", bus.out_kmer_num, 0);
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_mid_rst", bus.in_ready, 1);
    n0 = n_out;
    repeat (10) @(negedge clk);
    chk("no_out_after_rst", n_out - n0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
